// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer for load-use stalls, branch flushes and memory waits
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic RUN      = 1'b0;
    localparam logic MEM_WAIT = 1'b1;
    localparam int WW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [WW-1:0] TIMEOUT = WW'(MEM_TIMEOUT);

    logic [6:0]    opcode;
    logic [4:0]    rd, rs1, rs2, ex_rd;
    logic          uses_rs1, uses_rs2, ex_is_load, mem_stall, lu, state;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          unused_bits;

    assign opcode      = id_inst[6:0];
    assign rd          = id_inst[11:7];
    assign rs1         = id_inst[19:15];
    assign rs2         = id_inst[24:20];
    assign unused_bits = ^{id_inst[31:25], id_inst[14:12]};
    assign uses_rs1    = opcode inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH};
    assign uses_rs2    = opcode inside {OP_OP, OP_STORE, OP_BRANCH};
    assign mem_stall   = mem_req && !mem_ready;
    assign lu          = id_valid && ex_is_load && ex_rd != 5'd0 &&
                         ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));

    assign pc_we         = rst_n && !mem_stall && (ex_branch_taken || !lu);
    assign if_id_we      = pc_we;
    assign if_id_flush   = rst_n && !mem_stall && ex_branch_taken;
    assign id_ex_we      = rst_n && !mem_stall;
    assign ex_mem_we     = rst_n && !mem_stall;
    assign id_ex_bubble  = !rst_n || (!mem_stall && (ex_branch_taken || lu));
    assign mem_wb_bubble = !rst_n || mem_stall;

    always_comb begin
        wcnt_nxt = !mem_stall ? '0 : (state == RUN) ? WW'(1) : (&wcnt ? wcnt : wcnt + 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wcnt         <= '0;
            mem_err      <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_rd        <= 5'd0;
            lu_stall_cnt <= '0;
            flush_cnt    <= '0;
            mem_wait_cnt <= '0;
        end else begin
            state   <= mem_stall ? MEM_WAIT : RUN;
            wcnt    <= wcnt_nxt;
            mem_err <= mem_err || (mem_stall && wcnt_nxt >= TIMEOUT);
            if (id_ex_we) begin
                ex_is_load <= !id_ex_bubble && id_valid && opcode == OP_LOAD;
                ex_rd      <= id_ex_bubble ? 5'd0 : rd;
            end
            if (!mem_stall && !ex_branch_taken && lu && !(&lu_stall_cnt))
                lu_stall_cnt <= lu_stall_cnt + 1'b1;
            if (!mem_stall && ex_branch_taken && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
            if (mem_stall && !(&mem_wait_cnt))
                mem_wait_cnt <= mem_wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl with MEM_TIMEOUT=4
module tb_pipe_hazard_ctrl;
    localparam logic [6:0] C_RST  = 7'b0000101;
    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_MEM  = 7'b0000001;
    localparam logic [31:0] LW_X5   = 32'h0002A283;
    localparam logic [31:0] ADD_X5  = 32'h00728333;
    localparam logic [31:0] LW_X0   = 32'h00002003;
    localparam logic [31:0] ADD_X0  = 32'h00700333;
    localparam logic [31:0] LUI_X5  = 32'h000052B7;
    localparam logic [31:0] LUI_RS5 = 32'h0002A2B7;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic [31:0] id_inst = 32'd0;
    logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble, mem_err;
    logic [15:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;
    logic [6:0]  ctl;
    int          n_chk = 0, n_fail = 0;

    pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_inst(id_inst),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
        .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we), .mem_wb_bubble(mem_wb_bubble),
        .mem_err(mem_err), .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .mem_wait_cnt(mem_wait_cnt)
    );

    always #5 clk = ~clk;
    assign ctl = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic v, input logic [31:0] inst, input logic br,
                        input logic req, input logic rdy, input logic [6:0] exp_ctl);
        id_valid = v; id_inst = inst; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
        #3 check(tag, {25'd0, ctl}, {25'd0, exp_ctl});
        tick();
    endtask

    initial begin
        #2;
        check("rst_ctl", {25'd0, ctl}, {25'd0, C_RST});
        check("rst_cnt", {lu_stall_cnt, flush_cnt}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        // load-use: one bubble, IF/ID holds the dependent add
        step("lw_x5", 1, LW_X5, 0, 0, 0, C_NORM);
        step("lu_stall", 1, ADD_X5, 0, 0, 0, C_LU);
        step("lu_after", 1, ADD_X5, 0, 0, 0, C_NORM);
        check("lu_cnt1", lu_stall_cnt, 1);
        step("lw_x0", 1, LW_X0, 0, 0, 0, C_NORM);
        step("add_x0", 1, ADD_X0, 0, 0, 0, C_NORM);
        step("lw_x5b", 1, LW_X5, 0, 0, 0, C_NORM);
        step("lui_x5", 1, LUI_X5, 0, 0, 0, C_NORM);
        step("lw_x5c", 1, LW_X5, 0, 0, 0, C_NORM);
        step("lui_rs5", 1, LUI_RS5, 0, 0, 0, C_NORM);
        step("lw_x5d", 1, LW_X5, 0, 0, 0, C_NORM);
        step("inval", 0, ADD_X5, 0, 0, 0, C_NORM);
        check("lu_cnt_nochg", lu_stall_cnt, 1);
        // branch overrides load-use
        step("lw_x5e", 1, LW_X5, 0, 0, 0, C_NORM);
        step("br_lu", 1, ADD_X5, 1, 0, 0, C_BR);
        check("flush_cnt1", flush_cnt, 1);
        check("lu_cnt_br", lu_stall_cnt, 1);
        step("br_clr", 1, ADD_X5, 0, 0, 0, C_NORM);
        // EX held while memory stalls, hazard re-evaluated on release
        step("lw_x5f", 1, LW_X5, 0, 0, 0, C_NORM);
        step("mstall_a", 1, ADD_X5, 0, 1, 0, C_MEM);
        step("mstall_b", 1, ADD_X5, 0, 1, 0, C_MEM);
        step("mrel_lu", 1, ADD_X5, 0, 1, 1, C_LU);
        check("lu_cnt2", lu_stall_cnt, 2);
        check("mwait2", mem_wait_cnt, 2);
        step("mrel_norm", 1, ADD_X5, 0, 0, 0, C_NORM);
        // branch held during memory stall flushes once on release
        for (int i = 0; i < 3; i++) step("mstall_br", 0, 32'd0, 1, 1, 0, C_MEM);
        check("mwait5", mem_wait_cnt, 5);
        step("mrel_br", 0, 32'd0, 1, 1, 1, C_BR);
        check("flush_cnt2", flush_cnt, 2);
        check("err_none", mem_err, 0);
        // timeout after the 4th consecutive wait cycle
        for (int i = 0; i < 3; i++) step("tmo_stall", 0, 32'd0, 0, 1, 0, C_MEM);
        check("err_at3", mem_err, 0);
        step("tmo_stall4", 0, 32'd0, 0, 1, 0, C_MEM);
        check("err_at4", mem_err, 1);
        step("tmo_stall5", 0, 32'd0, 0, 1, 0, C_MEM);
        step("tmo_rel", 0, 32'd0, 0, 1, 1, C_NORM);
        check("err_sticky", mem_err, 1);
        check("mwait10", mem_wait_cnt, 10);
        // saturate mem_wait_cnt, then reset mid-stall
        id_valid = 0; ex_branch_taken = 0; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 65530; i++) tick();
        check("mwait_sat", mem_wait_cnt, 16'hFFFF);
        tick();
        check("mwait_hold", mem_wait_cnt, 16'hFFFF);
        step("lw_x5g", 1, LW_X5, 0, 0, 0, C_NORM);
        id_inst = ADD_X5;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctl", {25'd0, ctl}, {25'd0, C_RST});
        check("arst_cnt", {lu_stall_cnt, flush_cnt}, 32'd0);
        check("arst_mw", mem_wait_cnt, 0);
        check("arst_err", mem_err, 0);
        tick();
        rst_n = 1'b1;
        step("post_rst", 1, ADD_X5, 0, 0, 0, C_NORM);
        for (int i = 0; i < 3; i++) step("post_stall", 0, 32'd0, 0, 1, 0, C_MEM);
        check("post_err", mem_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
